// File: rtl/fu_branch_pipe.sv
// +-----------------------------------------------------------------------------+
// | fu_branch_pipe                                                              |
// | Two-stage branch/jump unit: E-stage resolve plus a DEPTH-entry completion   |
// | FIFO. Optional macro BR_MISALIGN_CHECK_EN adds complete_misaligned.         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fu_branch_pipe #(
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [3:0]         issue_op,
  input  logic [XLEN-1:0]    issue_pc,
  input  logic [XLEN-1:0]    issue_vj,
  input  logic [XLEN-1:0]    issue_vk,
  input  logic [XLEN-1:0]    issue_imm,
  input  logic [4:0]         issue_rd,
  input  logic [ORDER_W-1:0] issue_order,
  input  logic               issue_pred_taken,
  input  logic [XLEN-1:0]    issue_pred_target,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_target,
  output logic               complete_valid,
  input  logic               complete_ready,
  output logic [4:0]         complete_rd,
  output logic [XLEN-1:0]    complete_data,
  output logic [XLEN-1:0]    complete_pc_wdata,
  output logic [ORDER_W-1:0] complete_order,
  output logic               complete_mispredict,
`ifdef BR_MISALIGN_CHECK_EN
  output logic               complete_misaligned,
`endif
  output logic               busy
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [XLEN-1:0]  FOUR     = XLEN'(4);

  localparam logic [3:0] OP_JAL  = 4'b1000;
  localparam logic [3:0] OP_JALR = 4'b1001;

  // ---------------------------------------------------------------------------
  // E stage
  // ---------------------------------------------------------------------------
  logic               e_valid_q;
  logic [3:0]         e_op_q;
  logic [XLEN-1:0]    e_pc_q;
  logic [XLEN-1:0]    e_vj_q;
  logic [XLEN-1:0]    e_vk_q;
  logic [XLEN-1:0]    e_imm_q;
  logic [4:0]         e_rd_q;
  logic [ORDER_W-1:0] e_order_q;
  logic               e_pred_taken_q;
  logic [XLEN-1:0]    e_pred_target_q;

  logic w_issue_fire;
  logic w_e_adv;
  logic w_push;
  logic w_pop;

  assign w_issue_fire = issue_valid && issue_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      e_valid_q <= 1'b0;
    end else if (w_issue_fire) begin
      e_valid_q <= 1'b1;
    end else if (w_e_adv) begin
      e_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_op_q          <= '0;
      e_pc_q          <= '0;
      e_vj_q          <= '0;
      e_vk_q          <= '0;
      e_imm_q         <= '0;
      e_rd_q          <= '0;
      e_order_q       <= '0;
      e_pred_taken_q  <= 1'b0;
      e_pred_target_q <= '0;
    end else if (w_issue_fire) begin
      e_op_q          <= issue_op;
      e_pc_q          <= issue_pc;
      e_vj_q          <= issue_vj;
      e_vk_q          <= issue_vk;
      e_imm_q         <= issue_imm;
      e_rd_q          <= issue_rd;
      e_order_q       <= issue_order;
      e_pred_taken_q  <= issue_pred_taken;
      e_pred_target_q <= issue_pred_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Resolve
  // ---------------------------------------------------------------------------
  logic            w_is_br;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_is_jump;
  logic [2:0]      w_funct3;
  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_br_cond;
  logic            w_taken;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_pc_rel;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_link;
  logic [4:0]      w_rd;
  logic            w_mispredict;
  logic            w_misaligned;
  logic            w_report_misp;

  assign w_is_br   = !e_op_q[3];
  assign w_is_jal  = (e_op_q == OP_JAL);
  assign w_is_jalr = (e_op_q == OP_JALR);
  assign w_is_jump = w_is_jal || w_is_jalr;
  assign w_funct3  = e_op_q[2:0];

  assign w_eq   = (e_vj_q == e_vk_q);
  assign w_lt_s = ($signed(e_vj_q) < $signed(e_vk_q));
  assign w_lt_u = (e_vj_q < e_vk_q);

  // funct3 010/011 are reserved and resolve as not-taken
  always_comb begin
    w_br_cond = 1'b0;
    case (w_funct3)
      3'b000:  w_br_cond = w_eq;
      3'b001:  w_br_cond = !w_eq;
      3'b100:  w_br_cond = w_lt_s;
      3'b101:  w_br_cond = !w_lt_s;
      3'b110:  w_br_cond = w_lt_u;
      3'b111:  w_br_cond = !w_lt_u;
      default: w_br_cond = 1'b0;
    endcase
  end

  assign w_taken    = w_is_jump || (w_is_br && w_br_cond);
  assign w_jalr_sum = e_vj_q + e_imm_q;
  assign w_pc_rel   = e_pc_q + e_imm_q;
  assign w_target   = w_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_pc_rel;
  assign w_seq_pc   = e_pc_q + FOUR;
  assign w_next_pc  = w_taken ? w_target : w_seq_pc;
  assign w_link     = w_is_jump ? w_seq_pc : '0;
  assign w_rd       = w_is_jump ? e_rd_q : 5'd0;

  assign w_mispredict = (w_taken != e_pred_taken_q) ||
                        (w_taken && (w_target != e_pred_target_q));

`ifdef BR_MISALIGN_CHECK_EN
  assign w_misaligned = w_taken && (w_next_pc[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // A misaligned target is handed to the trap path instead of redirecting
  assign w_report_misp = w_mispredict && !w_misaligned;

  // ---------------------------------------------------------------------------
  // Completion FIFO
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic [4:0]         fifo_rd_q    [DEPTH];
  logic [XLEN-1:0]    fifo_data_q  [DEPTH];
  logic [XLEN-1:0]    fifo_npc_q   [DEPTH];
  logic [ORDER_W-1:0] fifo_order_q [DEPTH];
  logic               fifo_misp_q  [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign complete_valid = (count_q != '0);
  assign w_pop          = complete_valid && complete_ready;
  assign w_e_adv        = e_valid_q && ((count_q < FULL_CNT) || w_pop);
  assign w_push         = w_e_adv;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (w_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every read is gated by complete_valid
  always_ff @(posedge clk) begin
    if (w_push && !flush && !rst) begin
      fifo_rd_q[wr_ptr_q]    <= w_rd;
      fifo_data_q[wr_ptr_q]  <= w_link;
      fifo_npc_q[wr_ptr_q]   <= w_next_pc;
      fifo_order_q[wr_ptr_q] <= e_order_q;
      fifo_misp_q[wr_ptr_q]  <= w_report_misp;
    end
  end

`ifdef BR_MISALIGN_CHECK_EN
  logic fifo_mis_q [DEPTH];

  always_ff @(posedge clk) begin
    if (w_push && !flush && !rst) begin
      fifo_mis_q[wr_ptr_q] <= w_misaligned;
    end
  end

  assign complete_misaligned = complete_valid ? fifo_mis_q[rd_ptr_q] : 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign issue_ready         = !e_valid_q || w_e_adv;
  assign redirect_valid      = w_e_adv && w_report_misp;
  assign redirect_target     = e_valid_q ? w_next_pc : '0;
  assign complete_rd         = complete_valid ? fifo_rd_q[rd_ptr_q]    : 5'd0;
  assign complete_data       = complete_valid ? fifo_data_q[rd_ptr_q]  : '0;
  assign complete_pc_wdata   = complete_valid ? fifo_npc_q[rd_ptr_q]   : '0;
  assign complete_order      = complete_valid ? fifo_order_q[rd_ptr_q] : '0;
  assign complete_mispredict = complete_valid ? fifo_misp_q[rd_ptr_q]  : 1'b0;
  assign busy                = e_valid_q || complete_valid;

endmodule

`default_nettype wire

// File: tb/tb_fu_branch_pipe.sv
// +-----------------------------------------------------------------------------+
// | tb_fu_branch_pipe                                                           |
// | Directed and random checks of fu_branch_pipe against a queue-based model.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fu_branch_pipe;

  localparam int XLEN    = 32;
  localparam int ORDER_W = 64;
  localparam int DEPTH   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               fl = 1'b0;
  logic               iv = 1'b0;
  logic [3:0]         op = '0;
  logic [XLEN-1:0]    pc = '0, vj = '0, vk = '0, imm = '0, ptgt = '0;
  logic [4:0]         rd = '0;
  logic [ORDER_W-1:0] ord = '0;
  logic               pt = 1'b0;
  logic               cr = 1'b0;

  logic               issue_ready, redirect_valid, complete_valid;
  logic               complete_mispredict, busy;
  logic [XLEN-1:0]    redirect_target, complete_data, complete_pc_wdata;
  logic [4:0]         complete_rd;
  logic [ORDER_W-1:0] complete_order;
`ifdef BR_MISALIGN_CHECK_EN
  logic               complete_misaligned;
`endif

  fu_branch_pipe #(.XLEN(XLEN), .ORDER_W(ORDER_W), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (fl),
    .issue_valid         (iv),
    .issue_ready         (issue_ready),
    .issue_op            (op),
    .issue_pc            (pc),
    .issue_vj            (vj),
    .issue_vk            (vk),
    .issue_imm           (imm),
    .issue_rd            (rd),
    .issue_order         (ord),
    .issue_pred_taken    (pt),
    .issue_pred_target   (ptgt),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .complete_valid      (complete_valid),
    .complete_ready      (cr),
    .complete_rd         (complete_rd),
    .complete_data       (complete_data),
    .complete_pc_wdata   (complete_pc_wdata),
    .complete_order      (complete_order),
    .complete_mispredict (complete_mispredict),
`ifdef BR_MISALIGN_CHECK_EN
    .complete_misaligned (complete_misaligned),
`endif
    .busy                (busy)
  );

  typedef struct packed {
    logic [4:0]         rd;
    logic [XLEN-1:0]    data;
    logic [XLEN-1:0]    npc;
    logic [XLEN-1:0]    tgt;
    logic               taken;
    logic               misp;
    logic [ORDER_W-1:0] order;
  } res_t;

  bit   m_ev = 1'b0;
  res_t m_e;
  res_t m_q[$];

  int passes = 0;
  int fails  = 0;
  int checks = 0;
  logic [ORDER_W-1:0] next_ord = 64'd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural outcome of one instruction, straight from the ISA rules
  function automatic res_t model(input logic [3:0] o, input logic [XLEN-1:0] p,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] im, input logic [4:0] d,
                                 input logic [ORDER_W-1:0] tag, input logic ptk,
                                 input logic [XLEN-1:0] ptg);
    res_t r;
    logic t;
    logic [XLEN-1:0] tg;
    r = '0;
    r.order = tag;
    t  = 1'b0;
    tg = p + im;
    if (o[3] == 1'b0) begin
      case (o[2:0])
        3'd0: t = (a == b);
        3'd1: t = (a != b);
        3'd4: t = ($signed(a) <  $signed(b));
        3'd5: t = ($signed(a) >= $signed(b));
        3'd6: t = (a <  b);
        3'd7: t = (a >= b);
        default: t = 1'b0;
      endcase
    end else if (o == 4'd8) begin
      t = 1'b1; r.data = p + 4; r.rd = d;
    end else if (o == 4'd9) begin
      t = 1'b1; tg = (a + im) & 32'hFFFF_FFFE; r.data = p + 4; r.rd = d;
    end
    r.taken = t;
    r.tgt   = tg;
    r.npc   = t ? tg : p + 4;
    r.misp  = (t != ptk) || (t && (tg != ptg));
    return r;
  endfunction

  task automatic check_all();
    bit   pop, adv;
    res_t h;
    pop = (m_q.size() > 0) && cr;
    adv = m_ev && ((m_q.size() < DEPTH) || pop);
    h   = (m_q.size() > 0) ? m_q[0] : '0;
    chk("issue_ready", issue_ready, !m_ev || adv);
    chk("redirect_valid", redirect_valid, adv && m_e.misp);
    if (adv && m_e.misp) chk("redirect_target", redirect_target, m_e.npc);
    chk("complete_valid", complete_valid, m_q.size() > 0);
    chk("complete_rd", complete_rd, h.rd);
    chk("complete_data", complete_data, h.data);
    chk("complete_pc_wdata", complete_pc_wdata, h.npc);
    chk("complete_order", complete_order, h.order);
    chk("complete_mispredict", complete_mispredict, h.misp);
    chk("busy", busy, m_ev || (m_q.size() > 0));
  endtask

  task automatic update();
    bit pop, adv, acc;
    if (rst || fl) begin
      m_ev = 1'b0;
      m_q.delete();
    end else begin
      pop = (m_q.size() > 0) && cr;
      adv = m_ev && ((m_q.size() < DEPTH) || pop);
      acc = iv && (!m_ev || adv);
      if (pop) void'(m_q.pop_front());
      if (adv) m_q.push_back(m_e);
      if (acc) begin
        m_ev = 1'b1;
        m_e  = model(op, pc, vj, vk, imm, rd, ord, pt, ptgt);
      end else if (adv) begin
        m_ev = 1'b0;
      end
    end
  endtask

  // Entered at a falling edge with inputs already driven
  task automatic tick();
    #1;
    if (!rst) check_all();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] o, input logic [XLEN-1:0] p,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] im, input logic [4:0] d,
                       input logic ptk, input logic [XLEN-1:0] ptg);
    iv = 1'b1; op = o; pc = p; vj = a; vk = b; imm = im; rd = d;
    pt = ptk; ptgt = ptg; ord = next_ord;
    next_ord++;
  endtask

  function automatic logic [XLEN-1:0] rnd32();
    case ($urandom % 3)
      0:       return $urandom;
      1:       return $urandom % 4;
      default: return 32'hFFFF_FFFF - ($urandom % 4);
    endcase
  endfunction

  initial begin
    res_t r;
    m_e = '0;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_target", redirect_target, 0);
    chk("rst_complete_valid", complete_valid, 0);
    chk("rst_complete_pc", complete_pc_wdata, 0);
    chk("rst_busy", busy, 0);
    cr = 1'b1;
    tick();

    // BEQ taken, predicted not taken
    issue(4'b0000, 32'h100, 32'd5, 32'd5, 32'h20, 5'd7, 1'b0, 32'h0);
    tick();
    iv = 1'b0;
    #1;
    chk("beq_redirect_valid", redirect_valid, 1);
    chk("beq_redirect_target", redirect_target, 32'h120);
    tick();
    #1;
    chk("beq_complete_valid", complete_valid, 1);
    chk("beq_complete_pc", complete_pc_wdata, 32'h120);
    chk("beq_complete_misp", complete_mispredict, 1);
    chk("beq_complete_rd", complete_rd, 0);
    tick();

    // BLT / BLTU with the same operands, both predicted correctly
    issue(4'b0100, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 5'd0, 1'b1, 32'h340);
    tick();
    issue(4'b0110, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 5'd0, 1'b0, 32'h0);
    #1;
    chk("blt_no_redirect", redirect_valid, 0);
    tick();
    iv = 1'b0;
    #1;
    chk("bltu_no_redirect", redirect_valid, 0);
    chk("blt_complete_pc", complete_pc_wdata, 32'h340);
    tick();
    #1;
    chk("bltu_complete_pc", complete_pc_wdata, 32'h304);
    tick();

    // JALR clears bit 0 of the target
    issue(4'b1001, 32'h200, 32'h1003, 32'd0, 32'd0, 5'd5, 1'b1, 32'h1002);
    tick();
    iv = 1'b0;
    #1;
    chk("jalr_no_redirect", redirect_valid, 0);
    tick();
    #1;
    chk("jalr_complete_data", complete_data, 32'h204);
    chk("jalr_complete_pc", complete_pc_wdata, 32'h1002);
    chk("jalr_complete_rd", complete_rd, 5);
    tick();

    // Backpressure: DEPTH+1 instructions held before issue_ready drops
    cr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(4'b1000, 32'h400 + 32'(i * 4), 32'd0, 32'd0, 32'h10, 5'd1, 1'b1,
            32'h410 + 32'(i * 4));
      tick();
    end
    issue(4'b1000, 32'h40C, 32'd0, 32'd0, 32'h10, 5'd1, 1'b1, 32'h41C);
    #1;
    chk("bp_issue_ready_low", issue_ready, 0);
    tick();
    tick();
    cr = 1'b1;
    tick();
    iv = 1'b0;
    repeat (5) tick();

    // Flush while stalled, with an issue presented in the flush cycle
    cr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(4'b0000, 32'h500 + 32'(i * 4), 32'd9, 32'd9, 32'h8, 5'd0, 1'b0, 32'h0);
      tick();
    end
    issue(4'b1000, 32'h600, 32'd0, 32'd0, 32'h8, 5'd3, 1'b1, 32'h608);
    fl = 1'b1;
    tick();
    fl = 1'b0;
    iv = 1'b0;
    #1;
    chk("flush_complete_valid", complete_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_issue_ready", issue_ready, 1);
    chk("flush_redirect_valid", redirect_valid, 0);
    chk("flush_redirect_target", redirect_target, 0);
    chk("flush_complete_order", complete_order, 0);
    repeat (3) tick();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      logic [3:0] o;
      logic [XLEN-1:0] p, a, b, im;
      int sel;
      sel = $urandom % 10;
      if (sel < 6)       o = {1'b0, 3'($urandom % 8)};
      else if (sel < 8)  o = 4'b1000;
      else if (sel == 8) o = 4'b1001;
      else               o = 4'(4'd10 + ($urandom % 6));
      p  = {$urandom, 2'b00} & 32'h0000_FFFC;
      a  = rnd32();
      b  = ($urandom % 3 == 0) ? a : rnd32();
      im = ($urandom % 4 == 0) ? 32'($urandom % 64) : 32'(($urandom % 64) * 4);
      r  = model(o, p, a, b, im, 5'($urandom), 0, 1'b0, 32'h0);
      issue(o, p, a, b, im, 5'($urandom),
            ($urandom % 4 == 0) ? !r.taken : r.taken,
            ($urandom % 4 == 0) ? (r.tgt ^ 32'h4) : r.tgt);
      iv = ($urandom % 4 != 0);
      cr = ($urandom % 4 != 0);
      fl = ($urandom % 50 == 0);
      tick();
    end
    iv = 1'b0; fl = 1'b0; cr = 1'b1;
    repeat (6) tick();
    #1;
    chk("drain_busy", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
